// File: rtl/mask_pkg.sv
// Shared types and constants for the mask stream generator.
package mask_pkg;

    // Which colour component is thresholded.
    typedef enum logic [1:0] {
        CH_R    = 2'd0,
        CH_G    = 2'd1,
        CH_B    = 2'd2,
        CH_LUMA = 2'd3
    } chan_sel_t;

    // Frame-level control states.
    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        ACTIVE   = 2'd1,
        DRAIN    = 2'd2,
        TAB      = 2'd3
    } state_t;

    // Input-to-valid_out latency in cycles.
    localparam int PIPE_LAT = 3;

    // BT.601-style luma weights, scaled by 256.
    localparam logic [7:0] LUMA_R = 8'd77;
    localparam logic [7:0] LUMA_G = 8'd150;
    localparam logic [7:0] LUMA_B = 8'd29;

endpackage

// File: rtl/channel_extract.sv
// Combinational RGB565 to 8-bit channel value (R, G, B or luma).
module channel_extract
    import mask_pkg::*;
(
    input  logic [15:0] pixel_in,
    input  logic [1:0]  sel_in,
    output logic [7:0]  value_out
);

    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [17:0] luma_sum;
    logic        luma_unused;

    // Expand each component to 8 bits by replicating its top bits into the LSBs.
    assign r8 = {pixel_in[15:11], pixel_in[15:13]};
    assign g8 = {pixel_in[10:5],  pixel_in[10:9]};
    assign b8 = {pixel_in[4:0],   pixel_in[4:2]};

    // Weights sum to 256, so the weighted sum never exceeds 16 bits.
    assign luma_sum = 18'(LUMA_R) * 18'(r8)
                    + 18'(LUMA_G) * 18'(g8)
                    + 18'(LUMA_B) * 18'(b8);

    // Bits dropped by the >>8 and the guaranteed-zero top bits.
    assign luma_unused = ^{luma_sum[17:16], luma_sum[7:0]};

    // Select the requested channel.
    always_comb begin
        value_out = r8;
        case (chan_sel_t'(sel_in))
            CH_R:    value_out = r8;
            CH_G:    value_out = g8;
            CH_B:    value_out = b8;
            CH_LUMA: value_out = luma_sum[15:8];
            default: value_out = r8;
        endcase
    end

endmodule

// File: rtl/mask_stream_gen.sv
// Thresholds a pixel stream and emits coordinates of masked pixels plus an
// end-of-frame tabulate pulse with the frame's masked-pixel count.
//
// Stream semantics: there is no back-pressure. pixel_valid_in qualifies
// pixel/hcount/vcount for exactly one cycle; valid_out qualifies x_out/y_out
// for exactly one cycle. tabulate_out is a one-cycle strobe and never
// coincides with valid_out.
module mask_stream_gen
    import mask_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 720
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [15:0] pixel_in,
    input  logic        pixel_valid_in,
    input  logic [1:0]  channel_sel_in,
    input  logic [7:0]  lower_in,
    input  logic [7:0]  upper_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic        valid_out,
    output logic        tabulate_out,
    output logic [20:0] mask_count_out
);

    state_t      state;
    state_t      state_next;
    logic        drain_cnt;
    logic        accept;
    logic        start;
    logic        is_origin;
    logic        is_last;

    logic [1:0]  cfg_sel;
    logic [7:0]  cfg_lower;
    logic [7:0]  cfg_upper;

    logic        s1_valid;
    logic [15:0] s1_pixel;
    logic [10:0] s1_x;
    logic [9:0]  s1_y;

    logic        s2_valid;
    logic [7:0]  s2_value;
    logic [10:0] s2_x;
    logic [9:0]  s2_y;

    logic [7:0]  ext_value;
    logic        masked;
    logic [20:0] run_count;

    assign is_origin = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign is_last   = (hcount_in == 11'(H_ACTIVE - 1)) && (vcount_in == 10'(V_ACTIVE - 1));

    // FSM state register and drain timer (two cycles in DRAIN empties S1/S2).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= WAIT_SOF;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // Next-state and pixel-acceptance decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        start      = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (pixel_valid_in && is_origin) begin
                    accept     = 1'b1;
                    start      = 1'b1;
                    state_next = is_last ? DRAIN : ACTIVE;
                end
            end
            ACTIVE: begin
                if (pixel_valid_in) begin
                    accept = 1'b1;
                    if (is_last) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt) state_next = TAB;
            end
            TAB: begin
                state_next = WAIT_SOF;
            end
            default: state_next = WAIT_SOF;
        endcase
    end

    // Frame configuration is captured only at start of frame.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cfg_sel   <= 2'd0;
            cfg_lower <= 8'd0;
            cfg_upper <= 8'd0;
        end else if (start) begin
            cfg_sel   <= channel_sel_in;
            cfg_lower <= lower_in;
            cfg_upper <= upper_in;
        end
    end

    channel_extract u_extract (
        .pixel_in  (s1_pixel),
        .sel_in    (cfg_sel),
        .value_out (ext_value)
    );

    // An inverted window (lower > upper) can never satisfy both bounds.
    assign masked = s2_valid && (s2_value >= cfg_lower) && (s2_value <= cfg_upper);

    // Three-stage pipeline: S1 input, S2 channel value, S3 compare/output.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid  <= 1'b0;
            s1_pixel  <= 16'd0;
            s1_x      <= 11'd0;
            s1_y      <= 10'd0;
            s2_valid  <= 1'b0;
            s2_value  <= 8'd0;
            s2_x      <= 11'd0;
            s2_y      <= 10'd0;
            valid_out <= 1'b0;
            x_out     <= 11'd0;
            y_out     <= 10'd0;
        end else begin
            s1_valid  <= accept;
            s1_pixel  <= pixel_in;
            s1_x      <= hcount_in;
            s1_y      <= vcount_in;
            s2_valid  <= s1_valid;
            s2_value  <= ext_value;
            s2_x      <= s1_x;
            s2_y      <= s1_y;
            valid_out <= masked;
            x_out     <= s2_x;
            y_out     <= s2_y;
        end
    end

    // Running count tracks the S3 load so it already includes the last beat in TAB.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            run_count <= 21'd0;
        end else if (start) begin
            run_count <= 21'd0;
        end else if (masked && (run_count != {21{1'b1}})) begin
            run_count <= run_count + 21'd1;
        end
    end

    // End-of-frame strobe and published count, registered out of TAB.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tabulate_out   <= 1'b0;
            mask_count_out <= 21'd0;
        end else begin
            tabulate_out <= (state == TAB);
            if (state == TAB) mask_count_out <= run_count;
        end
    end

endmodule

// File: tb/tb_mask_stream_gen.sv
// Randomized bench for mask_stream_gen with a frame-level reference model.
module tb_mask_stream_gen;

    localparam int H = 24;
    localparam int V = 24;
    localparam int NPIX = H * V;
    localparam int W = 53;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [15:0] pixel_in;
    logic        pixel_valid_in;
    logic [1:0]  channel_sel_in;
    logic [7:0]  lower_in;
    logic [7:0]  upper_in;
    logic [10:0] x_out;
    logic [9:0]  y_out;
    logic        valid_out;
    logic        tabulate_out;
    logic [20:0] mask_count_out;

    mask_stream_gen #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .pixel_in       (pixel_in),
        .pixel_valid_in (pixel_valid_in),
        .channel_sel_in (channel_sel_in),
        .lower_in       (lower_in),
        .upper_in       (upper_in),
        .x_out          (x_out),
        .y_out          (y_out),
        .valid_out      (valid_out),
        .tabulate_out   (tabulate_out),
        .mask_count_out (mask_count_out)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];   // {cycle, x, y}
    logic [W-1:0] tab_q[$];   // {cycle, count}
    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;
    bit rst_seen = 0;
    int exp_mask = 0;
    int beats = 0;
    int tabs  = 0;
    int last_x = -1;
    int last_y = -1;

    // reference model state
    bit m_in_frame = 0;
    int m_ready_cyc = 0;
    int m_sel = 0;
    int m_lo = 0;
    int m_hi = 0;
    int m_cnt = 0;
    int m_last_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    // Channel value straight from the colour-format rules.
    function automatic int chan_val(input logic [15:0] p, input int sel);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        case (sel)
            0: return r8;
            1: return g8;
            2: return b8;
            default: return (77 * r8 + 150 * g8 + 29 * b8) / 256;
        endcase
    endfunction

    function automatic logic [15:0] pix_for(input int mode, input int h, input int v);
        case (mode)
            1: return 16'hFFFF;
            2: return (h == 10 && v == 20) ? 16'hF800 : 16'h0000;
            3: return 16'h07E0;
            5: return ((h + v) % 3 == 0) ? 16'hF800 : 16'h7800;
            default: return 16'($urandom);
        endcase
    endfunction

    // Frame-level behaviour: what each accepted pixel should produce, and when.
    task automatic model_pixel(input int h, input int v, input logic [15:0] p);
        int val;
        if (!m_in_frame && cyc >= m_ready_cyc && h == 0 && v == 0) begin
            m_in_frame = 1;
            m_sel = int'(channel_sel_in);
            m_lo  = int'(lower_in);
            m_hi  = int'(upper_in);
            m_cnt = 0;
        end
        if (m_in_frame) begin
            val = chan_val(p, m_sel);
            if (val >= m_lo && val <= m_hi) begin
                exp_q.push_back({32'(cyc + 3), 11'(h), 10'(v)});
                if (m_cnt < 2097151) m_cnt++;
            end
            if (h == H - 1 && v == V - 1) begin
                tab_q.push_back({32'(cyc + 4), 21'(m_cnt)});
                m_last_cnt = m_cnt;
                m_in_frame = 0;
                m_ready_cyc = cyc + 4;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_pix(input int h, input int v, input logic [15:0] p);
        @(posedge clk_in);
        #1;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        pixel_in = p;
        pixel_valid_in = 1'b1;
        model_pixel(h, v, p);
    endtask

    task automatic drive_idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
            pixel_valid_in = 1'b0;
            hcount_in = 11'($urandom_range(0, 2047));
            vcount_in = 10'($urandom_range(0, 1023));
            pixel_in = 16'($urandom);
        end
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        pixel_valid_in = 1'b0;
        m_in_frame = 0;
        m_ready_cyc = cyc + 1;
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    task automatic set_cfg(input int sel, input int lo, input int hi);
        channel_sel_in = 2'(sel);
        lower_in = 8'(lo);
        upper_in = 8'(hi);
    endtask

    // Drives a raster from (sh,sv); optional lower_in change at (0,chg_v);
    // optional reset one cycle after pixel (rst_h,rst_v).
    task automatic drive_frame(input int mode, input int sh, input int sv,
                               input int chg_v, input int chg_lo,
                               input int rst_h, input int rst_v);
        for (int v = sv; v < V; v++) begin
            for (int h = (v == sv) ? sh : 0; h < H; h++) begin
                if (mode == 0 && $urandom_range(0, 7) == 0) drive_idle(1);
                if (h == 0 && v == chg_v) lower_in = 8'(chg_lo);
                drive_pix(h, v, pix_for(mode, h, v));
                if (h == rst_h && v == rst_v) begin
                    do_reset();
                    return;
                end
            end
            drive_idle($urandom_range(0, 2));
        end
        drive_idle(6);
    endtask

    int b0 = 0;
    int t0 = 0;
    task automatic snap();
        b0 = beats;
        t0 = tabs;
    endtask

    task automatic check_frame(input string tag, input int exp_cnt, input int exp_tabs);
        @(negedge clk_in);
        check({tag, "_beats"}, 32'(beats - b0), 32'(exp_cnt));
        check({tag, "_tabs"}, 32'(tabs - t0), 32'(exp_tabs));
        if (exp_tabs > 0) check({tag, "_count"}, 32'(mask_count_out), 32'(exp_cnt));
    endtask

    // ---------------- cycle-accurate monitor ----------------
    always @(negedge clk_in) begin
        if (mon_en) begin
            logic [W-1:0] e;
            bit ev;
            if (rst_seen) begin
                exp_mask = 0;
                rst_seen = 0;
            end
            ev = (exp_q.size() > 0) && (exp_q[0][52:21] == 32'(cyc));
            check("valid_out", 32'(valid_out), 32'(ev));
            if (ev) begin
                e = exp_q.pop_front();
                if (valid_out) begin
                    check("x_out", 32'(x_out), 32'(e[20:10]));
                    check("y_out", 32'(y_out), 32'(e[9:0]));
                end
            end
            if (valid_out) begin
                beats++;
                last_x = int'(x_out);
                last_y = int'(y_out);
            end
            ev = (tab_q.size() > 0) && (tab_q[0][52:21] == 32'(cyc));
            check("tabulate_out", 32'(tabulate_out), 32'(ev));
            if (ev) begin
                e = tab_q.pop_front();
                exp_mask = int'(e[20:0]);
            end
            if (tabulate_out) tabs++;
            check("mask_count_out", 32'(mask_count_out), 32'(exp_mask));
            if (rst_in) begin
                for (int i = exp_q.size() - 1; i >= 0; i--)
                    if (exp_q[i][52:21] > 32'(cyc)) exp_q.delete(i);
                for (int i = tab_q.size() - 1; i >= 0; i--)
                    if (tab_q[i][52:21] > 32'(cyc)) tab_q.delete(i);
                rst_seen = 1;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int n_pat;
        rst_in = 1'b1;
        hcount_in = 11'd0;
        vcount_in = 10'd0;
        pixel_in = 16'd0;
        pixel_valid_in = 1'b0;
        set_cfg(0, 0, 0);
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        m_ready_cyc = cyc;
        mon_en = 1;
        @(negedge clk_in);
        check("rst_x_out", 32'(x_out), 32'd0);
        check("rst_y_out", 32'(y_out), 32'd0);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_tabulate_out", 32'(tabulate_out), 32'd0);
        check("rst_mask_count", 32'(mask_count_out), 32'd0);

        // full white frame, red window [200,255]
        set_cfg(0, 200, 255); snap();
        drive_frame(1, 0, 0, -1, 0, -1, -1);
        check_frame("white_r", NPIX, 1);

        // single red pixel at (10,20)
        set_cfg(0, 128, 255); snap();
        drive_frame(2, 0, 0, -1, 0, -1, -1);
        check_frame("single_r", 1, 1);
        check("single_r_x", 32'(last_x), 32'd10);
        check("single_r_y", 32'(last_y), 32'd20);

        // same frame on green: no beats, tabulate still fires
        set_cfg(1, 128, 255); snap();
        drive_frame(2, 0, 0, -1, 0, -1, -1);
        check_frame("single_g", 0, 1);

        // luma of pure green is 149
        set_cfg(3, 149, 149); snap();
        drive_frame(3, 0, 0, -1, 0, -1, -1);
        check_frame("luma_149", NPIX, 1);
        set_cfg(3, 150, 255); snap();
        drive_frame(3, 0, 0, -1, 0, -1, -1);
        check_frame("luma_150", 0, 1);

        // mid-frame threshold change only takes effect next frame
        set_cfg(0, 0, 255); snap();
        drive_frame(0, 0, 0, 10, 255, -1, -1);
        check_frame("midchg_cur", NPIX, 1);
        n_pat = 0;
        for (int v = 0; v < V; v++)
            for (int h = 0; h < H; h++)
                if ((h + v) % 3 == 0) n_pat++;
        snap();
        drive_frame(5, 0, 0, -1, 0, -1, -1);
        check_frame("midchg_next", n_pat, 1);

        // stream joined mid-frame: nothing until next origin
        set_cfg(0, 0, 255); snap();
        drive_frame(0, 5, 5, -1, 0, -1, -1);
        check_frame("late_start", 0, 0);

        // reset mid-frame
        drive_frame(0, 0, 0, -1, 0, 12, 15);
        snap();
        drive_idle(5);
        @(negedge clk_in);
        check("rst_mid_beats", 32'(beats - b0), 32'd0);
        check("rst_mid_tabs", 32'(tabs - t0), 32'd0);
        check("rst_mid_count", 32'(mask_count_out), 32'd0);
        set_cfg(0, 200, 255); snap();
        drive_frame(1, 0, 0, -1, 0, -1, -1);
        check_frame("post_rst", NPIX, 1);

        // inverted window masks nothing
        set_cfg(2, 200, 100); snap();
        drive_frame(0, 0, 0, -1, 0, -1, -1);
        check_frame("inverted", 0, 1);

        // random configurations against the model
        for (int f = 0; f < 5; f++) begin
            set_cfg($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255));
            snap();
            drive_frame(0, 0, 0, -1, 0, -1, -1);
            @(negedge clk_in);
            check("rand_tabs", 32'(tabs - t0), 32'd1);
            check("rand_count", 32'(mask_count_out), 32'(m_last_cnt));
            check("rand_beats", 32'(beats - b0), 32'(m_last_cnt));
        end

        drive_idle(4);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("tab_q_empty", 32'(tab_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
